// File: rtl/ram_dma_pkg.sv
// Shared types and helpers for the RAM DMA engine.
package ram_dma_pkg;

  typedef enum logic {
    COPY = 1'b0,
    FILL = 1'b1
  } dma_mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } dma_state_t;

  // A forward copy is unsafe when the destination starts inside the source
  // window past its first word: diff = (dst - src) mod 2**ADDR_W in [1, len-1].
  // Arguments are zero-extended by the caller.
  function automatic logic overlap_hazard(input logic [31:0] diff,
                                          input logic [31:0] len);
    return (diff != 32'd0) && (diff < len);
  endfunction

endpackage

// File: rtl/ram_dma_addr_gen.sv
// Loadable base address plus word index; address wraps modulo 2**ADDR_W while
// the index is LEN_W wide so a full-memory pass ends exactly on its last word.
module ram_dma_addr_gen #(
  parameter int ADDR_W = 10,
  parameter int LEN_W  = ADDR_W + 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_base,
  input  logic              i_step,
  input  logic [LEN_W-1:0]  i_len,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_last
);

  logic [ADDR_W-1:0] r_base;
  logic [LEN_W-1:0]  r_idx;
  logic [LEN_W-1:0]  w_idx_nxt;

  // Base captured on load; index restarts at 0 and advances per issued word.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_base <= '0;
      r_idx  <= '0;
    end else if (i_load) begin
      r_base <= i_base;
      r_idx  <= '0;
    end else if (i_step) begin
      r_idx  <= w_idx_nxt;
    end
  end

  assign w_idx_nxt = r_idx + LEN_W'(1);
  assign o_addr    = r_base + r_idx[ADDR_W-1:0];
  assign o_last    = (w_idx_nxt == i_len);

endmodule

// File: rtl/ram_dma_engine.sv
// Block copy/fill engine driving a dual-port RAM: port 0 reads, port 1 writes.
// Optional macro RAM_DMA_CHECKSUM_EN adds a sum-of-written-words output.
module ram_dma_engine
  import ram_dma_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int LEN_W  = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_mode,
  input  logic [ADDR_W-1:0] cmd_src,
  input  logic [ADDR_W-1:0] cmd_dst,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] cmd_fill_data,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] ram_address_0,
  output logic              ram_writeEnable_0,
  input  logic [DATA_W-1:0] ram_readData_0,
  output logic [ADDR_W-1:0] ram_address_1,
  output logic              ram_writeEnable_1,
  output logic [DATA_W-1:0] ram_writeData_1
`ifdef RAM_DMA_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  dma_state_t        r_state, w_state_nxt;
  dma_mode_t         r_mode;
  logic [LEN_W-1:0]  r_len;
  logic [DATA_W-1:0] r_fill;
  logic              r_err;
  logic              r_wr_pipe;

  logic              w_accept, w_hazard, w_reject;
  logic              w_rd_step, w_we1, w_rd_last, w_wr_last;
  logic [ADDR_W-1:0] w_diff, w_rd_addr, w_wr_addr;
  logic [DATA_W-1:0] w_wdata;

  assign w_accept = cmd_valid && (r_state == IDLE);
  assign w_diff   = cmd_dst - cmd_src;
  assign w_hazard = (cmd_mode == COPY) && overlap_hazard(32'(w_diff), 32'(cmd_len));
  assign w_reject = (cmd_len == '0) || w_hazard;

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state and handshake/status outputs.
  always_comb begin
    w_state_nxt = r_state;
    cmd_ready   = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    error       = 1'b0;
    unique case (r_state)
      IDLE: begin
        cmd_ready = 1'b1;
        // Empty or hazardous commands skip straight to completion.
        if (cmd_valid) w_state_nxt = w_reject ? FIN : RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (r_mode == COPY) begin
          if (w_rd_last) w_state_nxt = DRAIN;
        end else if (w_wr_last) begin
          w_state_nxt = FIN;
        end
      end
      DRAIN: begin
        busy        = 1'b1;
        w_state_nxt = FIN;
      end
      FIN: begin
        done        = 1'b1;
        error       = r_err;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Command fields frozen at acceptance.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_mode <= COPY;
      r_len  <= '0;
      r_fill <= '0;
      r_err  <= 1'b0;
    end else if (w_accept) begin
      r_mode <= dma_mode_t'(cmd_mode);
      r_len  <= cmd_len;
      r_fill <= cmd_fill_data;
      r_err  <= w_hazard;
    end
  end

  // Copy writes trail their reads by one cycle to match RAM read latency.
  always_ff @(posedge clk) begin
    if (!reset) r_wr_pipe <= 1'b0;
    else        r_wr_pipe <= w_rd_step;
  end

  assign w_rd_step = (r_state == RUN) && (r_mode == COPY);
  assign w_we1     = r_wr_pipe || ((r_state == RUN) && (r_mode == FILL));

  ram_dma_addr_gen #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_rd_gen (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_load  (w_accept),
    .i_base  (cmd_src),
    .i_step  (w_rd_step),
    .i_len   (r_len),
    .o_addr  (w_rd_addr),
    .o_last  (w_rd_last)
  );

  ram_dma_addr_gen #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_wr_gen (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_load  (w_accept),
    .i_base  (cmd_dst),
    .i_step  (w_we1),
    .i_len   (r_len),
    .o_addr  (w_wr_addr),
    .o_last  (w_wr_last)
  );

  assign w_wdata           = (r_mode == FILL) ? r_fill : ram_readData_0;
  assign ram_address_0     = w_rd_step ? w_rd_addr : '0;
  assign ram_writeEnable_0 = 1'b0;
  assign ram_address_1     = w_we1 ? w_wr_addr : '0;
  assign ram_writeEnable_1 = w_we1;
  assign ram_writeData_1   = w_we1 ? w_wdata : '0;

`ifdef RAM_DMA_CHECKSUM_EN
  logic [DATA_W-1:0] r_csum;

  // Running sum of every word written by the current command.
  always_ff @(posedge clk) begin
    if (!reset)        r_csum <= '0;
    else if (w_accept) r_csum <= '0;
    else if (w_we1)    r_csum <= r_csum + w_wdata;
  end

  assign checksum = r_csum;
`endif

endmodule

// File: tb/tb_ram_dma_engine.sv
// Directed bench for ram_dma_engine with a behavioural dual-port RAM.
module tb_ram_dma_engine;
  localparam int DW = 32, AW = 10, LW = 11, DEPTH = 1024;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid, cmd_ready, cmd_mode;
  logic [AW-1:0] cmd_src, cmd_dst;
  logic [LW-1:0] cmd_len;
  logic [DW-1:0] cmd_fill_data;
  logic          busy, done, error;
  logic [AW-1:0] ram_address_0, ram_address_1;
  logic          ram_writeEnable_0, ram_writeEnable_1;
  logic [DW-1:0] ram_readData_0, ram_writeData_1;
`ifdef RAM_DMA_CHECKSUM_EN
  logic [DW-1:0] checksum;
  logic [DW-1:0] done_csum;
`endif

  always #5 clk = ~clk;

  ram_dma_engine #(.DATA_W(DW), .ADDR_W(AW), .LEN_W(LW)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
    .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_len(cmd_len),
    .cmd_fill_data(cmd_fill_data),
    .busy(busy), .done(done), .error(error),
    .ram_address_0(ram_address_0), .ram_writeEnable_0(ram_writeEnable_0),
    .ram_readData_0(ram_readData_0),
    .ram_address_1(ram_address_1), .ram_writeEnable_1(ram_writeEnable_1),
    .ram_writeData_1(ram_writeData_1)
`ifdef RAM_DMA_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  // RAM model: registered read on port 0, write on port 1, one-cycle bulk init.
  logic [DW-1:0] mem     [DEPTH];
  logic [DW-1:0] exp_mem [DEPTH];
  logic          mem_init = 1'b0;

  function automatic logic [DW-1:0] pat(input int a);
    return 32'hC0DE_0000 | 32'(a);
  endfunction

  always @(posedge clk) begin
    ram_readData_0 <= mem[ram_address_0];
    if (mem_init) begin
      for (int a = 0; a < DEPTH; a++) mem[a] <= pat(a);
    end else if (ram_writeEnable_1) begin
      mem[ram_address_1] <= ram_writeData_1;
    end
  end

  typedef struct {
    logic          mode;
    logic [AW-1:0] src;
    logic [AW-1:0] dst;
    logic [LW-1:0] len;
    logic [DW-1:0] fill;
    logic          exp_err;
    int            exp_lat;
    int            exp_first;
    int            exp_nwr;
  } vec_t;

  vec_t vt [12];
  int   n_tests = 0, n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic init_mem();
    @(negedge clk); mem_init = 1'b1;
    @(negedge clk); mem_init = 1'b0;
    for (int a = 0; a < DEPTH; a++) exp_mem[a] = pat(a);
  endtask

  function automatic int mem_mism();
    int m = 0;
    for (int a = 0; a < DEPTH; a++) if (mem[a] !== exp_mem[a]) m++;
    return m;
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    string tag;
    int lat, first, nwr, bad;
    logic err;
    tag = $sformatf("v%0d", idx);
    init_mem();
    if (!v.exp_err)
      for (int i = 0; i < int'(v.len); i++)
        exp_mem[(int'(v.dst) + i) % DEPTH] = v.mode ? v.fill : pat((int'(v.src) + i) % DEPTH);
    @(negedge clk);
    check({tag, " ready"}, 32'(cmd_ready), 1);
    cmd_valid = 1'b1; cmd_mode = v.mode; cmd_src = v.src; cmd_dst = v.dst;
    cmd_len = v.len; cmd_fill_data = v.fill;
    @(posedge clk);
    lat = -1; first = 0; nwr = 0; bad = 0; err = 1'bx;
    for (int k = 1; k <= v.exp_lat + 20; k++) begin
      @(negedge clk);
      if (k == 1) begin
        // Scramble fields after acceptance; the engine must have latched them.
        cmd_valid = 1'b0; cmd_mode = ~v.mode; cmd_src = ~v.src; cmd_dst = ~v.dst;
        cmd_len = 11'h7; cmd_fill_data = ~v.fill;
      end
      if (ram_writeEnable_0) bad++;
      if (ram_writeEnable_1) begin nwr++; if (first == 0) first = k; end
      if (done) begin
        lat = k; err = error;
        if (busy) bad++;
`ifdef RAM_DMA_CHECKSUM_EN
        done_csum = checksum;
`endif
        break;
      end
      if (busy !== 1'b1 || error) bad++;
    end
    check({tag, " latency"}, lat, v.exp_lat);
    check({tag, " error"}, 32'(err), 32'(v.exp_err));
    check({tag, " first_wr"}, first, v.exp_first);
    check({tag, " n_writes"}, nwr, v.exp_nwr);
    check({tag, " ctl_bad"}, bad, 0);
    check({tag, " mem_mism"}, mem_mism(), 0);
  endtask

  initial begin
    int nrdy, d1, d2, bad;

    vt[0]  = '{1'b0, 10'h010, 10'h200, 11'd4,    32'h0,         1'b0, 6,    2, 4};
    vt[1]  = '{1'b1, 10'h000, 10'h3FE, 11'd4,    32'hDEADBEEF,  1'b0, 5,    1, 4};
    vt[2]  = '{1'b0, 10'h100, 10'h102, 11'd8,    32'h0,         1'b1, 1,    0, 0};
    vt[3]  = '{1'b0, 10'h020, 10'h040, 11'd0,    32'h0,         1'b0, 1,    0, 0};
    vt[4]  = '{1'b1, 10'h000, 10'h040, 11'd0,    32'hCAFEF00D,  1'b0, 1,    0, 0};
    vt[5]  = '{1'b0, 10'h050, 10'h050, 11'd3,    32'h0,         1'b0, 5,    2, 3};
    vt[6]  = '{1'b0, 10'h3FD, 10'h005, 11'd5,    32'h0,         1'b0, 7,    2, 5};
    vt[7]  = '{1'b0, 10'h102, 10'h100, 11'd8,    32'h0,         1'b0, 10,   2, 8};
    vt[8]  = '{1'b0, 10'h000, 10'h003, 11'd4,    32'h0,         1'b1, 1,    0, 0};
    vt[9]  = '{1'b0, 10'h000, 10'h004, 11'd4,    32'h0,         1'b0, 6,    2, 4};
    vt[10] = '{1'b1, 10'h000, 10'h123, 11'd1024, 32'h5A5A0001,  1'b0, 1025, 1, 1024};
    vt[11] = '{1'b1, 10'h000, 10'h010, 11'd3,    32'h00000005,  1'b0, 4,    1, 3};

    reset = 1'b0; cmd_valid = 1'b0; cmd_mode = 1'b0; cmd_src = '0; cmd_dst = '0;
    cmd_len = '0; cmd_fill_data = '0;
    repeat (3) @(negedge clk);
    check("rst ready", 32'(cmd_ready), 1);
    check("rst busy",  32'(busy), 0);
    check("rst done",  32'(done), 0);
    check("rst error", 32'(error), 0);
    check("rst we1",   32'(ram_writeEnable_1), 0);
    check("rst we0",   32'(ram_writeEnable_0), 0);
    check("rst addr0", 32'(ram_address_0), 0);
    check("rst addr1", 32'(ram_address_1), 0);
    check("rst wdata", ram_writeData_1, 0);
    reset = 1'b1;

    for (int i = 0; i < 12; i++) begin
      run_vec(vt[i], i);
`ifdef RAM_DMA_CHECKSUM_EN
      if (i == 2)  check("csum reject", done_csum, 32'h0);
      if (i == 4)  check("csum len0",   done_csum, 32'h0);
      if (i == 11) check("csum fill3",  done_csum, 32'h0000000F);
`endif
    end

    // cmd_valid held through a FILL; second command waits until after FIN.
    init_mem();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_mode = 1'b1; cmd_dst = 10'h080; cmd_len = 11'd3;
    cmd_fill_data = 32'h11111111;
    @(posedge clk);
    nrdy = 0; d1 = -1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) begin cmd_dst = 10'h090; cmd_len = 11'd2; cmd_fill_data = 32'h22222222; end
      if (k <= 4 && cmd_ready) nrdy++;
      if (done && d1 < 0) d1 = k;
    end
    check("hold ready_busy", nrdy, 0);
    check("hold done1_lat", d1, 4);
    check("hold ready_k5", 32'(cmd_ready), 1);
    @(posedge clk);
    d2 = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) cmd_valid = 1'b0;
      if (done) begin d2 = k; break; end
    end
    check("hold done2_lat", d2, 3);
    check("hold mem80", mem[10'h080], 32'h11111111);
    check("hold mem82", mem[10'h082], 32'h11111111);
    check("hold mem83", mem[10'h083], pat(10'h083));
    check("hold mem90", mem[10'h090], 32'h22222222);
    check("hold mem91", mem[10'h091], 32'h22222222);
    check("hold mem92", mem[10'h092], pat(10'h092));

    // Reset during COPY of 16 words: writes 0..4 land, nothing after.
    init_mem();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_mode = 1'b0; cmd_src = 10'h000; cmd_dst = 10'h300; cmd_len = 11'd16;
    @(posedge clk);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) cmd_valid = 1'b0;
    end
    reset = 1'b0;
    @(negedge clk);
    check("abort we1",   32'(ram_writeEnable_1), 0);
    check("abort busy",  32'(busy), 0);
    check("abort ready", 32'(cmd_ready), 1);
    reset = 1'b1;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done || ram_writeEnable_1 || busy) bad++;
    end
    check("abort quiet", bad, 0);
    check("abort ready_after", 32'(cmd_ready), 1);
    bad = 0;
    for (int i = 0; i < 16; i++)
      if (mem[10'h300 + i] !== ((i < 5) ? pat(i) : pat(10'h300 + i))) bad++;
    check("abort mem", bad, 0);
    run_vec(vt[0], 99);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
